raster_arith_prims: RTL and testbench
=====================================

RASTER_ARITH_PRIMS -- requirements
Module: raster_arith_prims

Interface
REQ-001 SHALL have parameter WIDTH, default 14, giving the bit width of all data ports (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port add_a, input, WIDTH: adder operand A.
REQ-005 SHALL have port add_b, input, WIDTH: adder operand B.
REQ-006 SHALL have port add_cin, input, 1 bit: adder carry-in.
REQ-007 SHALL have port add_sum, output, WIDTH: adder sum.
REQ-008 SHALL have port add_cout, output, 1 bit: adder carry-out.
REQ-009 SHALL have port cmp_a, input, WIDTH: comparator operand A.
REQ-010 SHALL have port cmp_b, input, WIDTH: comparator operand B.
REQ-011 SHALL have port cmp_gt, output, 1 bit: A greater than B.
REQ-012 SHALL have port cmp_eq, output, 1 bit: A equal to B.
REQ-013 SHALL have port cmp_lt, output, 1 bit: A less than B.
REQ-014 SHALL have port cnt_d, input, WIDTH: counter load value.
REQ-015 SHALL have port cnt_clr, input, 1 bit: synchronous clear.
REQ-016 SHALL have port cnt_load, input, 1 bit: synchronous load.
REQ-017 SHALL have port cnt_up, input, 1 bit: count direction; 1 = increment, 0 = decrement.
REQ-018 SHALL have port cnt_en, input, 1 bit: count enable.
REQ-019 SHALL have port cnt_q, output, WIDTH: counter value.

Function
REQ-020 Adder SHALL be purely combinational, with zero-cycle latency: {add_cout, add_sum} = add_a + add_b + add_cin, computed at WIDTH+1 bits.
REQ-021 Adder operands SHALL be treated as raw bit vectors, so two's-complement subtraction works as A + ~B + 1 with add_cout discarded by the user.
REQ-022 Comparator SHALL be purely combinational and compare cmp_a against cmp_b as unsigned numbers.
REQ-023 Exactly one of cmp_gt, cmp_eq, cmp_lt SHALL be 1 at all times.
REQ-024 Counter SHALL be a WIDTH-bit register cnt_q that updates only on the rising edge of clk.
REQ-025 Counter priority per edge SHALL be: cnt_clr, which sets cnt_q to 0, above cnt_load, which sets cnt_q to cnt_d, above cnt_en, which counts, above hold.
REQ-026 When cnt_en = 1, cnt_clr = 0 and cnt_load = 0, cnt_q SHALL become cnt_q+1 if cnt_up = 1, else cnt_q-1.
REQ-027 Counter SHALL wrap modulo 2^WIDTH in both directions: all-ones+1 gives 0, and 0-1 gives all-ones; no saturation and no wrap flag.
REQ-028 cnt_up SHALL be ignored unless the counter is counting.
REQ-029 When cnt_load and cnt_en are asserted together, load SHALL win, with no count added in the same cycle.
REQ-030 Counter latency SHALL be one cycle: a control change is reflected on cnt_q after the next rising edge.
REQ-031 The block SHALL have no handshake; all inputs are sampled or evaluated every cycle.

Reset
REQ-032 Assertion of rst_n = 0 SHALL immediately force cnt_q to 0, regardless of clk.
REQ-033 rst_n SHALL override cnt_clr, cnt_load and cnt_en.
REQ-034 During reset, combinational outputs (add_sum, add_cout, cmp_gt, cmp_eq, cmp_lt) SHALL continue to reflect their inputs.
REQ-035 Reset asserted mid-count SHALL leave cnt_q at 0.
REQ-036 After deassertion of rst_n, the first rising edge SHALL apply the normal priority rules of REQ-025.

Verification
REQ-037 Adder test, WIDTH=14: add_a=0x0280, add_b=~0x0064+1, add_cin=0 -> add_sum=0x021C (640-100=540); add_a=0x3FFF, add_b=1, add_cin=0 -> add_sum=0, add_cout=1.
REQ-038 Comparator test: cmp_a=5, cmp_b=9 -> lt=1; cmp_a=cmp_b=320 -> eq=1; cmp_a=0x3FFF, cmp_b=0 -> gt=1 (unsigned).
REQ-039 Counter count and wrap test: reset, then cnt_en=1, cnt_up=1 for 3 edges -> cnt_q=3; cnt_up=0 for 4 edges -> cnt_q=0x3FFF.
REQ-040 Counter priority test: cnt_load=1, cnt_d=100, cnt_en=1 -> cnt_q=100 next edge; cnt_clr=1 with cnt_load=1 -> cnt_q=0.
REQ-041 Counter hold test: cnt_en=0 with all other controls 0 -> cnt_q unchanged over 5 edges.
REQ-042 Asynchronous reset test: with cnt_q=57, drive rst_n low between clock edges -> cnt_q=0 before the next edge, and stays 0 while rst_n is low even with cnt_en=1.

Source files
------------

// File: rtl/raster_arith_prims.sv
// Raster arithmetic primitives: combinational adder and unsigned comparator,
// plus a clear/load/up-down counter with asynchronous active-low reset.
module raster_arith_prims #(
    parameter int unsigned WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] add_a,
    input  logic [WIDTH-1:0] add_b,
    input  logic             add_cin,
    output logic [WIDTH-1:0] add_sum,
    output logic             add_cout,
    input  logic [WIDTH-1:0] cmp_a,
    input  logic [WIDTH-1:0] cmp_b,
    output logic             cmp_gt,
    output logic             cmp_eq,
    output logic             cmp_lt,
    input  logic [WIDTH-1:0] cnt_d,
    input  logic             cnt_clr,
    input  logic             cnt_load,
    input  logic             cnt_up,
    input  logic             cnt_en,
    output logic [WIDTH-1:0] cnt_q
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [WIDTH:0]   w_add_full;
    logic [WIDTH-1:0] w_cnt_next;
    logic [WIDTH-1:0] r_cnt;

    // Operands are raw bit vectors; the carry-out is the extra top bit.
    assign w_add_full = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
    assign add_sum    = w_add_full[WIDTH-1:0];
    assign add_cout   = w_add_full[WIDTH];

    assign cmp_gt = (cmp_a > cmp_b);
    assign cmp_eq = (cmp_a == cmp_b);
    assign cmp_lt = (cmp_a < cmp_b);

    // Clear beats load beats count; natural modulo wrap in both directions.
    always_comb begin
        w_cnt_next = r_cnt;
        if (cnt_clr) begin
            w_cnt_next = '0;
        end else if (cnt_load) begin
            w_cnt_next = cnt_d;
        end else if (cnt_en) begin
            w_cnt_next = cnt_up ? (r_cnt + CNT_ONE) : (r_cnt - CNT_ONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign cnt_q = r_cnt;

endmodule

// File: tb/tb_raster_arith_prims.sv
// Directed bench for raster_arith_prims: arithmetic reference model checked
// every cycle, plus hand-computed literal expectations.
module tb_raster_arith_prims;

    localparam int unsigned W   = 14;
    localparam longint      MOD = longint'(1) << W;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] add_a, add_b, add_sum;
    logic         add_cin, add_cout;
    logic [W-1:0] cmp_a, cmp_b;
    logic         cmp_gt, cmp_eq, cmp_lt;
    logic [W-1:0] cnt_d, cnt_q;
    logic         cnt_clr, cnt_load, cnt_up, cnt_en;

    int n_vec = 0;
    int n_err = 0;
    longint m_cnt = 0;

    raster_arith_prims #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout),
        .cmp_a    (cmp_a),
        .cmp_b    (cmp_b),
        .cmp_gt   (cmp_gt),
        .cmp_eq   (cmp_eq),
        .cmp_lt   (cmp_lt),
        .cnt_d    (cnt_d),
        .cnt_clr  (cnt_clr),
        .cnt_load (cnt_load),
        .cnt_up   (cnt_up),
        .cnt_en   (cnt_en),
        .cnt_q    (cnt_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Counter reference: plain integer arithmetic modulo 2^W.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)        m_cnt = 0;
        else if (cnt_clr)  m_cnt = 0;
        else if (cnt_load) m_cnt = longint'(cnt_d);
        else if (cnt_en)   m_cnt = cnt_up ? (m_cnt + 1) % MOD : (m_cnt + MOD - 1) % MOD;
    end

    always @(negedge clk) begin
        longint s;
        s = longint'(add_a) + longint'(add_b) + longint'(add_cin);
        chk("model_sum",  longint'(add_sum),  s % MOD);
        chk("model_cout", longint'(add_cout), s / MOD);
        chk("model_gt",   longint'(cmp_gt),   longint'(cmp_a > cmp_b));
        chk("model_eq",   longint'(cmp_eq),   longint'(cmp_a == cmp_b));
        chk("model_lt",   longint'(cmp_lt),   longint'(cmp_a < cmp_b));
        chk("model_cnt",  longint'(cnt_q),    m_cnt);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] t100;
    logic [W-1:0] tab_a [8];
    logic [W-1:0] tab_b [8];

    initial begin
        rst_n = 1'b0;
        {add_a, add_b, add_cin, cmp_a, cmp_b} = '0;
        {cnt_d, cnt_clr, cnt_load, cnt_up, cnt_en} = '0;
        cnt_en = 1'b1; cnt_up = 1'b1;
        tick(2);
        chk("reset_cnt", longint'(cnt_q), 0);
        cnt_en = 1'b0;
        rst_n = 1'b1;

        // Adder: 640 - 100 via two's complement
        t100 = 14'h0064;
        add_a = 14'h0280; add_b = ~t100 + 14'd1; add_cin = 1'b0;
        #1 chk("add_sub_sum", longint'(add_sum), 'h021C);
        add_a = 14'h3FFF; add_b = 14'h0001; add_cin = 1'b0;
        #1 chk("add_wrap_sum", longint'(add_sum), 0);
        chk("add_wrap_cout", longint'(add_cout), 1);
        add_a = 14'h3FFF; add_b = 14'h3FFF; add_cin = 1'b1;
        #1 chk("add_max_sum", longint'(add_sum), 'h3FFF);
        chk("add_max_cout", longint'(add_cout), 1);
        add_a = 14'd7; add_b = 14'd8; add_cin = 1'b1;
        #1 chk("add_cin_sum", longint'(add_sum), 16);

        // Comparator
        cmp_a = 14'd5; cmp_b = 14'd9;
        #1 chk("cmp_lt", longint'({cmp_gt, cmp_eq, cmp_lt}), 3'b001);
        cmp_a = 14'd320; cmp_b = 14'd320;
        #1 chk("cmp_eq", longint'({cmp_gt, cmp_eq, cmp_lt}), 3'b010);
        cmp_a = 14'h3FFF; cmp_b = 14'd0;
        #1 chk("cmp_gt_unsigned", longint'({cmp_gt, cmp_eq, cmp_lt}), 3'b100);

        // Directed table for adder/comparator, checked by the model each cycle
        tab_a = '{14'h0000, 14'h3FFF, 14'h2000, 14'h1FFF, 14'h0001, 14'h2AAA, 14'h1555, 14'h3FFE};
        tab_b = '{14'h0000, 14'h3FFF, 14'h1FFF, 14'h2000, 14'h3FFF, 14'h1555, 14'h2AAA, 14'h3FFF};
        for (int i = 0; i < 8; i++) begin
            add_a = tab_a[i]; add_b = tab_b[i]; add_cin = 1'(i % 2);
            cmp_a = tab_a[i]; cmp_b = tab_b[i];
            tick(1);
        end

        // Count up 3, then down 4 with wrap
        cnt_en = 1'b1; cnt_up = 1'b1;
        tick(3);
        chk("cnt_up3", longint'(cnt_q), 3);
        cnt_up = 1'b0;
        tick(4);
        chk("cnt_down_wrap", longint'(cnt_q), 'h3FFF);
        cnt_up = 1'b1;
        tick(1);
        chk("cnt_up_wrap", longint'(cnt_q), 0);

        // Priority: load over count, clear over load
        cnt_load = 1'b1; cnt_d = 14'd100; cnt_en = 1'b1;
        tick(1);
        chk("load_over_en", longint'(cnt_q), 100);
        cnt_clr = 1'b1;
        tick(1);
        chk("clr_over_load", longint'(cnt_q), 0);

        // Hold
        cnt_clr = 1'b0; cnt_load = 1'b1; cnt_d = 14'd57; cnt_en = 1'b0;
        tick(1);
        cnt_load = 1'b0; cnt_d = 14'd999; cnt_up = 1'b0;
        tick(5);
        chk("hold5", longint'(cnt_q), 57);

        // Asynchronous reset between edges
        #1 rst_n = 1'b0;
        #1 chk("async_rst", longint'(cnt_q), 0);
        cnt_en = 1'b1; cnt_up = 1'b1; cnt_load = 1'b1;
        tick(3);
        chk("rst_holds", longint'(cnt_q), 0);
        cnt_load = 1'b0;
        rst_n = 1'b1;
        tick(1);
        chk("post_rst_count", longint'(cnt_q), 1);
        cnt_en = 1'b0;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
